vna_point_buffer: RTL and testbench
===================================

VNA_POINT_BUFFER -- requirements
Module: vna_point_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, the FIFO depth in samples; it must be a power of two and at least 4.
REQ-002 SHALL have parameter IDXW, default 16, the width of the point index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port vna, input, 1 bit: VNA mode enable; low flushes the block.
REQ-006 SHALL have port vna_count, input, 16 bits: points per scan; 0 selects PC-scan mode.
REQ-007 SHALL have port in_strobe, input, 1 bit: one-cycle strobe from the scanner marking a new point.
REQ-008 SHALL have ports in_I and in_Q, input, 24 bits signed each: point I/Q data, held stable around in_strobe.
REQ-009 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): valid/ready handshake toward the packet assembler.
REQ-010 SHALL have ports out_I and out_Q, output, 24 bits signed each: buffered point data.
REQ-011 SHALL have port out_index, output, IDXW bits: 0 for the zero/sync sample, 1..vna_count for scan points.
REQ-012 SHALL have port out_sos, output, 1 bit: high when out_index is 0 (start of scan).
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a point is dropped.
REQ-014 SHALL have port dropped_count, output, 16 bits: saturating count of dropped points.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_SOS and RUN.
REQ-016 SHALL move IDLE->WAIT_SOS when vna=1 and vna_count!=0, latching vna_count into cnt_lat.
REQ-017 SHALL, in WAIT_SOS, treat the first in_strobe as index 0 (sync sample), push it with sos=1, and move to RUN.
REQ-018 SHALL, in RUN, increment the index on each in_strobe; a strobe arriving when index==cnt_lat wraps the index to 0, sets sos=1, and is pushed.
REQ-019 SHALL go to IDLE, empty the FIFO and clear the index from any state within 1 cycle when vna=0; overflow and dropped_count are held.
REQ-020 SHALL, when vna_count differs from cnt_lat in WAIT_SOS or RUN, flush the FIFO and go to WAIT_SOS, re-latching cnt_lat.
REQ-021 SHALL ignore in_strobe in IDLE, which includes PC-scan mode (vna_count==0).
REQ-022 SHALL store 24+24+IDXW+1 bits per FIFO entry.
REQ-023 SHALL register the FIFO output; a strobe written into an empty FIFO asserts out_valid on the following cycle.
REQ-024 SHALL pop on out_valid&&out_ready; out_I, out_Q, out_index and out_sos stay stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, when the FIFO is full, drop the incoming strobe, set overflow and increment dropped_count (saturating at 16'hFFFF); the index still advances, so later points keep their true index.
REQ-026 SHALL accept a push that coincides with a pop while full; that push is not a drop.
REQ-027 SHALL wrap the FIFO pointers modulo DEPTH and provide a 1-bit-extended full/empty distinction.
REQ-028 SHALL give a flush priority over a simultaneous push or pop in the same cycle.

Reset
REQ-029 SHALL, on rst_n=0, set the state to IDLE, empty the FIFO, and drive out_valid=0, out_I=0, out_Q=0, out_index=0, out_sos=0, overflow=0, dropped_count=0 and cnt_lat=0.
REQ-030 SHALL, when reset asserts mid-transfer, lose the pending output word without waiting for out_ready.
REQ-031 SHALL clear overflow and dropped_count only on reset.

Configuration
REQ-032 SHALL, with VNA_POINT_BUFFER_STATS_EN defined, implement overflow and dropped_count as specified above.
REQ-033 SHALL, without VNA_POINT_BUFFER_STATS_EN, tie overflow and dropped_count to 0; drop behaviour on full is otherwise identical.

Structure
REQ-034 SHALL place the FSM state enum, the entry struct (I, Q, index, sos) and the data width constant (24) in the shared package vna_pkg.
REQ-035 SHALL implement the storage as sub-module vna_sync_fifo (parameters WIDTH and DEPTH; push, pop and flush inputs; registered output); the FSM and indexing stay in the top module.

Verification
REQ-036 SHALL cover this scenario: vna_count=3 with 8 strobes at 1 per 6144 cycles and out_ready=1 -> indices 0,1,2,3,0,1,2,3, with sos on the 1st and 5th words.
REQ-037 SHALL cover this scenario: DEPTH=16, out_ready=0 and 20 strobes -> 16 words held, overflow=1, dropped_count=4; after releasing out_ready, the next strobe carries index 20 mod 4 = 0 (sos) when vna_count=3.
REQ-038 SHALL cover this scenario: an in_strobe in the same cycle as a pop while full -> no drop, dropped_count unchanged.
REQ-039 SHALL cover this scenario: vna dropped to 0 mid-scan with 5 words queued -> out_valid=0 the next cycle; re-enabling gives a first word with index 0 and sos=1.
REQ-040 SHALL cover this scenario: vna_count changed from 3 to 5 mid-scan -> flush, and the next strobe has index 0 with wrap after 5.
REQ-041 SHALL cover this scenario: rst_n pulsed low asynchronously while out_valid=1 -> all outputs 0 immediately; with the macro undefined, overflow stays 0 under the overflow scenario (REQ-037).

Source files
------------

// File: rtl/vna_pkg.sv
// vna_pkg: shared FSM states, point entry layout and data width for the VNA point buffer
package vna_pkg;
  localparam int DATA_W = 24;
  localparam int IDX_W = 16;
  typedef enum logic [1:0] {IDLE, WAIT_SOS, RUN} state_t;
  typedef struct packed {
    logic signed [DATA_W-1:0] i;
    logic signed [DATA_W-1:0] q;
    logic [IDX_W-1:0] index;
    logic sos;
  } point_t;
endpackage

// File: rtl/vna_sync_fifo.sv
// vna_sync_fifo: synchronous FIFO with extended pointers and a registered head word
module vna_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic do_push, do_pop;
  assign valid = wptr != rptr;
  assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign do_pop = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign wptr_n = wptr + (AW+1)'(do_push);
  assign rptr_n = rptr + (AW+1)'(do_pop);
  // storage array, left without reset so it can map onto RAM
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
  // pointers and head register; the head bypasses the array when the FIFO is (about to be) empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      dout <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      dout <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      dout <= (do_push && wptr == rptr_n) ? din : mem[rptr_n[AW-1:0]];
    end
endmodule

// File: rtl/vna_point_buffer.sv
// vna_point_buffer: indexes scanner points per scan and queues them for the packet assembler
// Define VNA_POINT_BUFFER_STATS_EN to enable the overflow flag and dropped-point counter.
module vna_point_buffer
  import vna_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDXW = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vna,
  input  logic [15:0]              vna_count,
  input  logic                     in_strobe,
  input  logic signed [DATA_W-1:0] in_I,
  input  logic signed [DATA_W-1:0] in_Q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_I,
  output logic signed [DATA_W-1:0] out_Q,
  output logic [IDXW-1:0]          out_index,
  output logic                     out_sos,
  output logic                     overflow,
  output logic [15:0]              dropped_count
);
  localparam int W = 2*DATA_W + IDXW + 1;
  state_t state, state_n;
  logic [15:0] cnt_lat, cnt_lat_n;
  logic [IDXW-1:0] idx, idx_n, idx_new;
  logic flush, take, accept, full, pop;
  logic [W-1:0] dout;
  assign pop = out_valid && out_ready;
  assign idx_new = (state == RUN && idx != IDXW'(cnt_lat)) ? idx + 1'b1 : '0;
  assign accept = take && (!full || pop);
  // scan sequencing: disable and count changes flush first, strobes are only taken once armed
  always_comb begin
    state_n = state;
    cnt_lat_n = cnt_lat;
    idx_n = idx;
    flush = 1'b0;
    take = 1'b0;
    if (!vna) begin
      state_n = IDLE;
      idx_n = '0;
      flush = 1'b1;
    end else if (state != IDLE && vna_count != cnt_lat) begin
      flush = 1'b1;
      idx_n = '0;
      cnt_lat_n = vna_count;
      state_n = vna_count != '0 ? WAIT_SOS : IDLE;
    end else if (state == IDLE) begin
      if (vna_count != '0) begin
        state_n = WAIT_SOS;
        cnt_lat_n = vna_count;
      end
    end else if (in_strobe) begin
      take = 1'b1;
      idx_n = idx_new;
      state_n = RUN;
    end
  end
  // FSM state, latched scan length and last assigned index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt_lat <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      cnt_lat <= cnt_lat_n;
      idx <= idx_n;
    end
  vna_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(accept),
    .pop(pop),
    .din({in_I, in_Q, idx_new, idx_new == '0}),
    .dout(dout),
    .valid(out_valid),
    .full(full)
  );
  assign {out_I, out_Q, out_index, out_sos} = dout;
`ifdef VNA_POINT_BUFFER_STATS_EN
  // sticky overflow and saturating drop count, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow <= 1'b0;
      dropped_count <= '0;
    end else if (take && !accept) begin
      overflow <= 1'b1;
      if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 1'b1;
    end
`else
  assign overflow = 1'b0;
  assign dropped_count = '0;
`endif
endmodule

// File: tb/tb_vna_point_buffer.sv
// tb_vna_point_buffer: directed scenarios checked against a queue-based scan model every cycle
`timescale 1ns/1ps
module tb_vna_point_buffer;
  localparam int DEPTH = 16;
`ifdef VNA_POINT_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 0, rst_n = 1, vna = 0, in_strobe = 0, out_ready = 0;
  logic [15:0] vna_count = 0;
  logic signed [23:0] in_I = 0, in_Q = 0;
  logic out_valid, out_sos, overflow;
  logic signed [23:0] out_I, out_Q;
  logic [15:0] out_index, dropped_count;
  int errors = 0, checks = 0;
  typedef struct {logic signed [23:0] i, q; int idx; bit sos;} word_t;
  word_t mq[$];
  word_t w;
  int seen_idx[$];
  bit seen_sos[$];
  bit m_armed = 0, m_synced = 0, m_ovf = 0, m_pop;
  int m_lat = 0, m_pos = 0, m_drops = 0;
  int e36[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int e40[8] = '{0, 1, 2, 3, 4, 5, 0, 1};

  always #5 clk = ~clk;

  vna_point_buffer #(.DEPTH(DEPTH), .IDXW(16)) dut (
    .clk(clk), .rst_n(rst_n), .vna(vna), .vna_count(vna_count), .in_strobe(in_strobe),
    .in_I(in_I), .in_Q(in_Q), .out_valid(out_valid), .out_ready(out_ready), .out_I(out_I),
    .out_Q(out_Q), .out_index(out_index), .out_sos(out_sos), .overflow(overflow),
    .dropped_count(dropped_count)
  );

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a scan is a sequence of strobes after the sync sample; index = position mod (count+1).
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_armed = 0; m_synced = 0; m_lat = 0; m_pos = 0; m_ovf = 0; m_drops = 0;
    end
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("out_I", out_I, mq[0].i);
      check("out_Q", out_Q, mq[0].q);
      check("out_index", out_index, mq[0].idx);
      check("out_sos", out_sos, mq[0].sos);
    end
    check("overflow", overflow, STATS && m_ovf);
    check("dropped_count", dropped_count, STATS ? m_drops : 0);
    if (rst_n) begin
      m_pop = mq.size() != 0 && out_ready;
      if (!vna) begin
        mq.delete(); m_armed = 0; m_synced = 0;
      end else if (m_armed && vna_count != m_lat) begin
        mq.delete(); m_lat = vna_count; m_armed = vna_count != 0; m_synced = 0;
      end else if (!m_armed) begin
        if (vna_count != 0) begin m_armed = 1; m_lat = vna_count; m_synced = 0; end
      end else begin
        if (m_pop) begin
          seen_idx.push_back(out_index);
          seen_sos.push_back(out_sos);
          void'(mq.pop_front());
        end
        if (in_strobe) begin
          if (!m_synced) begin m_synced = 1; m_pos = 0; end
          w.i = in_I; w.q = in_Q; w.idx = m_pos % (m_lat + 1); w.sos = w.idx == 0;
          m_pos++;
          if (mq.size() < DEPTH) mq.push_back(w);
          else begin m_ovf = 1; if (m_drops < 65535) m_drops++; end
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(int k);
    in_I = 24'(k * 1237 - 40000);
    in_Q = 24'(7 - k * 311);
    in_strobe = 1;
    tick();
    in_strobe = 0;
  endtask

  task automatic drain(string name);
    int n = 0;
    while (out_valid && n < 100) begin tick(); n++; end
    check(name, out_valid, 0);
  endtask

  initial begin
    #1 rst_n = 0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_I", out_I, 0);
    check("rst_Q", out_Q, 0);
    check("rst_index", out_index, 0);
    check("rst_sos", out_sos, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dropped", dropped_count, 0);
    tick(2);
    rst_n = 1;
    tick();
    // PC-scan mode: strobes ignored
    vna = 1; vna_count = 0; out_ready = 1;
    strobe(1); tick(2);
    check("pcscan_valid", out_valid, 0);
    // slow scan of 4 points, ready always high
    vna_count = 3; tick(2);
    seen_idx.delete(); seen_sos.delete();
    for (int k = 0; k < 8; k++) begin
      strobe(k);
      if (k == 0) begin
        check("first_valid", out_valid, 1);
        check("first_index", out_index, 0);
        check("first_sos", out_sos, 1);
      end
      tick(6143);
    end
    check("s36_count", seen_idx.size(), 8);
    for (int j = 0; j < 8 && j < seen_idx.size(); j++) begin
      check("s36_index", seen_idx[j], e36[j]);
      check("s36_sos", seen_sos[j], j == 0 || j == 4);
    end
    // overflow: 20 strobes into a stalled FIFO
    vna = 0; tick(); vna = 1; out_ready = 0; tick(2);
    seen_idx.delete(); seen_sos.delete();
    for (int k = 0; k < 20; k++) strobe(100 + k);
    tick();
    check("ovf_valid", out_valid, 1);
    check("ovf_head_index", out_index, 0);
    check("ovf_flag", overflow, STATS);
    check("ovf_dropped", dropped_count, STATS ? 4 : 0);
    out_ready = 1;
    drain("ovf_drain");
    check("ovf_held", seen_idx.size(), 16);
    if (seen_idx.size() == 16) check("ovf_last_index", seen_idx[15], 3);
    strobe(200);
    check("ovf_next_valid", out_valid, 1);
    check("ovf_next_index", out_index, 0);
    check("ovf_next_sos", out_sos, 1);
    // push coinciding with pop while full
    out_ready = 0;
    for (int k = 0; k < 15; k++) strobe(210 + k);
    out_ready = 1;
    strobe(300);
    out_ready = 0;
    check("fullpop_dropped", dropped_count, STATS ? 4 : 0);
    check("fullpop_valid", out_valid, 1);
    // disable mid-scan with 5 words queued
    vna = 0; tick(); vna = 1; tick(2);
    for (int k = 0; k < 5; k++) strobe(400 + k);
    vna = 0; tick();
    check("disable_valid", out_valid, 0);
    vna = 1; tick(2); out_ready = 1;
    strobe(500);
    check("reen_index", out_index, 0);
    check("reen_sos", out_sos, 1);
    // scan length change 3 -> 5 mid-scan
    out_ready = 0;
    strobe(501); strobe(502);
    vna_count = 5; tick();
    check("recount_flush", out_valid, 0);
    out_ready = 1;
    seen_idx.delete(); seen_sos.delete();
    for (int k = 0; k < 8; k++) begin strobe(600 + k); tick(); end
    tick(3);
    check("s40_count", seen_idx.size(), 8);
    for (int j = 0; j < 8 && j < seen_idx.size(); j++) begin
      check("s40_index", seen_idx[j], e40[j]);
      check("s40_sos", seen_sos[j], j == 0 || j == 6);
    end
    // asynchronous reset while a word is pending
    out_ready = 0;
    strobe(700); strobe(701); strobe(702);
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_I", out_I, 0);
    check("arst_Q", out_Q, 0);
    check("arst_index", out_index, 0);
    check("arst_sos", out_sos, 0);
    check("arst_overflow", overflow, 0);
    check("arst_dropped", dropped_count, 0);
    tick();
    rst_n = 1;
    tick(2);
    out_ready = 1;
    strobe(800);
    check("post_rst_index", out_index, 0);
    check("post_rst_sos", out_sos, 1);
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
